// File: rtl/fp32_pkg.sv
// Shared FP32 helpers for pooling and activation stages: constants, ReLU and a
// bit-level max that needs no floating-point hardware.
package fp32_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ZERO     = 32'h00000000;
    localparam int    FP_SIGN_BIT = 31;

    function automatic fp32_t fp32_relu(input fp32_t x);
        return x[FP_SIGN_BIT] ? FP_ZERO : x;
    endfunction

    // Sign-magnitude compare; on any tie (including +0 vs -0) the first operand wins.
    function automatic fp32_t fp32_max(input fp32_t a, input fp32_t b);
        logic sa;
        logic sb;
        sa = a[FP_SIGN_BIT];
        sb = b[FP_SIGN_BIT];
        if (sa != sb) begin
            if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
                return a;
            return sa ? b : a;
        end else if (!sa) begin
            return (b[30:0] > a[30:0]) ? b : a;
        end else begin
            return (b[30:0] < a[30:0]) ? b : a;
        end
    endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One-row buffer of horizontal pair maxima: synchronous write, registered read
// address, combinational read of the addressed word (infers block RAM).
module maxpool_line_buffer #(
    parameter int DEPTH      = 28,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_addr_q <= rd_addr;
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU + 2x2/stride-2 max pool for one FP32 feature-map channel.
// Stage 1 registers the activated pixel with its position; stage 2 pools it.
module relu_maxpool2x2
    import fp32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out_pixel,
    output logic                  done
);

    localparam int CW       = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
    localparam int AW       = CW - 1;
    localparam int LB_DEPTH = IMG_WIDTH / 2;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] pix_p1;
    logic [CW-1:0]         col_p1;
    logic [RW-1:0]         row_p1;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] lb_rd_data;
    logic [DATA_WIDTH-1:0] act;
    logic                  lb_wr_en;

    assign act      = (RELU_EN != 0) ? fp32_relu(data_in) : data_in;
    assign hmax     = fp32_max(pair_reg, pix_p1);
    assign lb_wr_en = vld_p1 & col_p1[0] & ~row_p1[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (data_valid_in) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Stage 1: activated pixel and its position
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
            col_p1 <= '0;
            row_p1 <= '0;
        end else begin
            vld_p1 <= data_valid_in;
            if (data_valid_in) begin
                pix_p1 <= act;
                col_p1 <= col;
                row_p1 <= row;
            end
        end
    end

    // Stage 2: horizontal pair max, then vertical max against the stored even row
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pair_reg        <= '0;
            data_out        <= '0;
            valid_out_pixel <= 1'b0;
            done            <= 1'b0;
        end else begin
            valid_out_pixel <= 1'b0;
            done            <= 1'b0;
            if (vld_p1) begin
                if (!col_p1[0]) begin
                    pair_reg <= pix_p1;
                end else if (row_p1[0]) begin
                    data_out        <= fp32_max(lb_rd_data, hmax);
                    valid_out_pixel <= 1'b1;
                    done            <= (col_p1 == CW'(IMG_WIDTH - 1)) &&
                                       (row_p1 == RW'(IMG_HEIGHT - 1));
                end
            end
        end
    end

    // Read address is captured on acceptance so the stored pair max is ready in stage 2.
    maxpool_line_buffer #(
        .DEPTH      (LB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (col_p1[CW-1:1]),
        .wr_data (hmax),
        .rd_en   (data_valid_in),
        .rd_addr (col[CW-1:1]),
        .rd_data (lb_rd_data)
    );

endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
Streaming ReLU followed by 2x2, stride-2 max pooling on FP32 feature-map pixels. The block sits directly downstream of one conv3d output channel. It consumes the raster-ordered data_out/valid_out_pixel stream of that channel, IMG_WIDTH x IMG_HEIGHT pixels per frame, with gaps between valid pixels allowed. It emits a (IMG_WIDTH/2) x (IMG_HEIGHT/2) pooled stream in the same handshake style for the next conv layer.

Parameters:
DATA_WIDTH, 32, pixel width; only IEEE-754 single precision is supported.
IMG_WIDTH, 56, input columns; must be even and >= 2.
IMG_HEIGHT, 56, input rows; must be even and >= 2.
RELU_EN, 1, 1 = clamp negatives to +0.0 before pooling; 0 = pool raw signed values.

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
data_valid_in  input  1  data_in is valid this cycle; one pixel is accepted per asserted cycle
data_in  input  DATA_WIDTH  FP32 pixel, raster order
data_out  output  DATA_WIDTH  pooled FP32 pixel
valid_out_pixel  output  1  one-cycle strobe per pooled pixel
done  output  1  one-cycle strobe coincident with the last pooled pixel of a frame

Behaviour:
- Reset (async, resetn=0):
  - col/row counters, pair register, stage registers, data_out, valid_out_pixel and done all go to 0.
  - The line buffer is not reset. Its contents are always written on an even row before being read on the odd row.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 with row+1. After pixel (W-1,H-1) both wrap to 0, so the next frame starts with no idle cycle.
- No-input cycles: with data_valid_in=0, all state holds and valid_out_pixel=0.
- Stage 1 (input edge):
  - The accepted pixel is ReLU'd: if RELU_EN and bit31=1, value = 32'h00000000; -0.0 also maps to +0.0.
  - The result is registered together with its col/row position.
- Stage 2, by position of the stage-1 pixel:
  - Even col: store the value in pair_reg.
  - Odd col: hmax = fpmax(pair_reg, value).
  - Even row, odd col: line_buf[col>>1] <= hmax.
  - Odd row, odd col: data_out <= fpmax(line_buf[col>>1], hmax) and valid_out_pixel <= 1.
- Latency: valid_out_pixel is high exactly in the cycle after the 2nd clock edge following acceptance of the bottom-right pixel of each window. Pooled outputs come out in raster order.
- done:
  - Asserted with valid_out_pixel for pooled pixel index (W/2)*(H/2)-1, i.e. window (W/2-1, H/2-1).
  - Otherwise 0.
- fpmax(a,b):
  - Signs differ: the non-negative operand wins; +0 and -0 compare equal, and a is returned on a tie.
  - Both non-negative: unsigned compare of bits[30:0].
  - Both negative: the smaller bits[30:0] wins.
  - Equal values: return a.
  - NaN inputs are out of scope; the result is whatever the bit compare gives, with no trap.
- Line buffer: W/2 entries x DATA_WIDTH, one write on even rows and one read on odd rows. Read and write never target the same row, so there is no hazard.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0).
- Back-to-back frames at full rate: no bubbles, and no output corruption across the boundary.

Decomposition:
- Shared package (fp32_pkg):
  - FP_ZERO = 32'h00000000, FP_SIGN_BIT = 31.
  - fp32_max function implementing fpmax above.
  - fp32_relu function.
  - Both functions are reused by future pooling and activation stages.
- One natural sub-module: maxpool_line_buffer.
  - Parameterised depth W/2 and width DATA_WIDTH.
  - Synchronous write, registered read address.
  - Maps to inferred RAM for W=224.

Test Plan:
1. 4x4 frame, continuous valid, row0 = {1.0,2.0,0.5,0.5}, row1 = {3.0,1.0,0.5,4.0}, rows2-3 all 1.0 (3F800000) -> outputs 40400000 (3.0), 40800000 (4.0), 3F800000, 3F800000. done only with the 4th output; each output 2 edges after its window's last input.
2. 4x4 frame of all -1.0 (BF800000), RELU_EN=1 -> four outputs 00000000. With RELU_EN=0 -> four outputs BF800000. A window {-1.0,-2.0,-3.0,-0.5} gives BF000000.
3. Same stimulus as 1 with data_valid_in toggled 1/0 every cycle -> identical output values and count; each valid_out_pixel 2 edges after the accepting edge.
4. Two 4x4 frames back-to-back, the second with all values +1 ulp -> 8 outputs; done on the 4th and 8th; no frame-2 data in frame-1 outputs.
5. resetn pulsed low after 6 pixels of a frame, then a full 4x4 frame of 2.0 -> exactly 4 outputs of 40000000; no output derived from pre-reset pixels.
6. Window {+0.0 (00000000), -0.0 (80000000), -0.0, -0.0}, RELU_EN=0 -> output 00000000 (first operand on tie).
